reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Multi-domain reset controller driven by the PLL lock. It filters the lock, then releases one active-low reset per downstream clock-enable domain in a fixed order with a programmable gap. On lock loss it re-asserts every domain reset. It also accepts a software reset request that re-runs the release sequence. It sits between the PLL and all datapath blocks and replaces ad-hoc per-block reset counters.

Parameters:
- NUM_DOMAINS, 4: number of sequenced reset outputs, 1..8.
- LOCK_FILTER_CYCLES, 100: consecutive cycles lock must stay high before the first release, 1..2^CNT_W.
- STAGE_GAP_CYCLES, 16: cycles between successive domain releases, 1..2^CNT_W.
- SW_HOLD_CYCLES, 32: minimum reset assertion for a software request, 1..2^CNT_W.
- CNT_W, 8: width of the shared cycle counter.

Ports:
- clk_In  input  1  system clock; the only clock.
- rst_n_In  input  1  asynchronous, active-low reset for the whole block.
- clk_lock  input  1  PLL lock; asynchronous to clk_In.
- sw_rst_req  input  1  single-cycle software reset request, synchronous to clk_In.
- rst_n_out  output  NUM_DOMAINS  per-domain active-low resets; bit 0 is released first.
- seq_done  output  1  high while all domains are released (RUN state).
- lock_lost  output  1  sticky flag: lock was lost after at least one full release.
- state_out  output  3  current state encoding, for debug.

Behaviour:
- Reset is decided as one clock with an asynchronous, active-low reset.
  - While rst_n_In=0: rst_n_out=0, seq_done=0, lock_lost=0, state=WAIT_LOCK, all counters 0.
  - Outputs are asserted asynchronously and released synchronously on the first edge after deassertion.
- clk_lock passes through a 2-FF synchronizer to give lock_s. This adds 2 cycles of latency. All decisions use lock_s.
- All outputs are registered.
- WAIT_LOCK:
  - rst_n_out all 0.
  - lock_s=1 → FILTER, cnt=0.
- FILTER:
  - rst_n_out all 0.
  - lock_s=0 → WAIT_LOCK. This restarts filtering; there is no partial credit.
  - On the LOCK_FILTER_CYCLES-th edge spent in FILTER → RELEASE, idx=0, cnt=0.
- RELEASE:
  - On the STAGE_GAP_CYCLES-th edge since the previous release (or since entry), set rst_n_out[idx]=1, idx++, cnt=0.
  - The edge that releases bit NUM_DOMAINS-1 also moves to RUN and sets seq_done=1.
  - Released bits stay at 1.
- RUN:
  - All rst_n_out=1, seq_done=1.
  - sw_rst_req=1 → HOLD, cnt=0.
- HOLD:
  - rst_n_out all 0, seq_done=0.
  - After SW_HOLD_CYCLES edges: if lock_s=1 → RELEASE (no re-filtering, idx=0); otherwise → WAIT_LOCK.
- Lock loss in RELEASE, RUN or HOLD:
  - On the next edge, all rst_n_out=0, seq_done=0, state=WAIT_LOCK.
  - If the state was RUN, lock_lost is set to 1. lock_lost is cleared only by rst_n_In.
- Priority when events coincide: rst_n_In > lock loss > sw_rst_req > counter expiry.
- sw_rst_req outside RUN is ignored; it is not queued.
- Re-assertion always covers all domains at once. Release is always in ascending order.
- cnt saturates and never wraps. With a parameter value of 1, the action happens on the first edge in the state.
- Illegal state encodings → WAIT_LOCK with all resets asserted.
- state_out encoding: WAIT_LOCK=0, FILTER=1, RELEASE=2, RUN=3, HOLD=4.

Optional Feature:
- RESET_SEQ_RELOCK_CNT_EN defined:
  - Adds output relock_cnt [7:0].
  - It increments on every RUN→WAIT_LOCK transition caused by lock loss and saturates at 255.
  - It is cleared only by rst_n_In.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum and its encodings;
  - the CNT_W default;
  - the RELOCK_CNT_W=8 constant.
- Sub-module sync_2ff: generic 2-flop synchronizer with an asynchronous active-low clear. It is used for clk_lock and is reusable elsewhere.
- The FSM and counters stay in reset_sequencer.

Test Plan:
- Nominal release (defaults):
  - Stimulus: clk_lock=1 before edge 1.
  - Required: FILTER after edge 3, RELEASE after edge 103. rst_n_out[0..3] rise after edges 119, 135, 151, 167. seq_done=1 after edge 167.
- Lock glitch during FILTER: drop clk_lock for 3 cycles at edge 50 → back to WAIT_LOCK. The full 100-cycle filter restarts from re-lock, and rst_n_out stays 4'b0000 throughout.
- Lock loss in RUN:
  - Stimulus: drop clk_lock.
  - Required: 3 edges later rst_n_out=4'b0000, seq_done=0, lock_lost=1.
  - Then: re-lock gives the full sequence again, and lock_lost stays 1.
- Software reset: sw_rst_req pulse in RUN → rst_n_out=0 for 32 cycles. rst_n_out[0] then rises 16 edges later, and the sequence completes without re-filtering.
- Lock loss mid-RELEASE: drop clk_lock after rst_n_out=4'b0011 → all bits return to 0, lock_lost stays 0, and state_out=0.
- Async reset: pulse rst_n_In low between clock edges in RUN → rst_n_out=0 and lock_lost=0 immediately, with no clock edge. With RESET_SEQ_RELOCK_CNT_EN, relock_cnt equals the number of lock-loss events and is cleared by rst_n_In.

Source files
------------

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq_pkg
// Brief    : State encodings and shared widths for the reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    localparam int CNT_W_DEFAULT = 8;
    localparam int RELOCK_CNT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Generic two-flop synchronizer with asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : PLL-lock filtered, ordered release of per-domain active-low resets.
//            Optional relock counter output: RESET_SEQ_RELOCK_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS        = 4,
    parameter int LOCK_FILTER_CYCLES = 100,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int SW_HOLD_CYCLES     = 32,
    parameter int CNT_W              = CNT_W_DEFAULT
) (
    input  logic                   clk_In,
    input  logic                   rst_n_In,
    input  logic                   clk_lock,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   seq_done,
    output logic                   lock_lost,
    output logic [2:0]             state_out
`ifdef RESET_SEQ_RELOCK_CNT_EN
    ,
    output logic [RELOCK_CNT_W-1:0] relock_cnt
`endif
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    // Terminal counts: the action fires on the N-th edge, counting from 0.
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(SW_HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DOMAINS - 1);

    logic                   lock_s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_out_q, rst_n_out_d, release_bit;
    logic                   seq_done_q, seq_done_d;
    logic                   lock_lost_q, lock_lost_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk_In),
        .rst_n (rst_n_In),
        .d_in  (clk_lock),
        .q_out (lock_s)
    );

    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign release_bit = NUM_DOMAINS'(1) << idx_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc;
        idx_d       = idx_q;
        rst_n_out_d = rst_n_out_q;
        seq_done_d  = seq_done_q;
        lock_lost_d = lock_lost_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                rst_n_out_d = '0;
                seq_done_d  = 1'b0;
                cnt_d       = '0;
                idx_d       = '0;
                if (lock_s) begin
                    state_d = ST_FILTER;
                end
            end
            ST_FILTER: begin
                rst_n_out_d = '0;
                seq_done_d  = 1'b0;
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILTER_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_d     = ST_WAIT_LOCK;
                    rst_n_out_d = '0;
                    seq_done_d  = 1'b0;
                    cnt_d       = '0;
                end else if (cnt_q == GAP_LAST) begin
                    rst_n_out_d = rst_n_out_q | release_bit;
                    idx_d       = idx_q + IDX_W'(1);
                    cnt_d       = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_RUN;
                        seq_done_d = 1'b1;
                        idx_d      = '0;
                    end
                end
            end
            ST_RUN: begin
                rst_n_out_d = '1;
                seq_done_d  = 1'b1;
                cnt_d       = '0;
                if (!lock_s) begin
                    state_d     = ST_WAIT_LOCK;
                    rst_n_out_d = '0;
                    seq_done_d  = 1'b0;
                    lock_lost_d = 1'b1;
                end else if (sw_rst_req) begin
                    state_d     = ST_HOLD;
                    rst_n_out_d = '0;
                    seq_done_d  = 1'b0;
                end
            end
            ST_HOLD: begin
                rst_n_out_d = '0;
                seq_done_d  = 1'b0;
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    // Lock never dropped, so the filter is skipped on re-release.
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d     = ST_WAIT_LOCK;
                rst_n_out_d = '0;
                seq_done_d  = 1'b0;
                cnt_d       = '0;
                idx_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk_In or negedge rst_n_In) begin
        if (!rst_n_In) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_n_out_q <= '0;
            seq_done_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_n_out_q <= rst_n_out_d;
            seq_done_q  <= seq_done_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign rst_n_out = rst_n_out_q;
    assign seq_done  = seq_done_q;
    assign lock_lost = lock_lost_q;
    assign state_out = state_q;

`ifdef RESET_SEQ_RELOCK_CNT_EN
    logic [RELOCK_CNT_W-1:0] relock_cnt_q, relock_cnt_d;

    // Lock loss has top priority in RUN, so this is exactly the RUN->WAIT_LOCK exit.
    always_comb begin
        relock_cnt_d = relock_cnt_q;
        if ((state_q == ST_RUN) && !lock_s && !(&relock_cnt_q)) begin
            relock_cnt_d = relock_cnt_q + RELOCK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_In or negedge rst_n_In) begin
        if (!rst_n_In) begin
            relock_cnt_q <= '0;
        end else begin
            relock_cnt_q <= relock_cnt_d;
        end
    end

    assign relock_cnt = relock_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Scoreboard bench: expectations are queued against edge numbers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int K_RST    = 0;
    localparam int K_DONE   = 1;
    localparam int K_LOST   = 2;
    localparam int K_STATE  = 3;
    localparam int K_RELOCK = 4;

    typedef struct {
        int          edge_no;
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic       clk_In     = 1'b0;
    logic       rst_n_In   = 1'b0;
    logic       clk_lock   = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [3:0] rst_n_out;
    logic       seq_done;
    logic       lock_lost;
    logic [2:0] state_out;
`ifdef RESET_SEQ_RELOCK_CNT_EN
    logic [7:0] relock_cnt;
`endif

    int   edge_no  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    reset_sequencer dut (
        .clk_In     (clk_In),
        .rst_n_In   (rst_n_In),
        .clk_lock   (clk_lock),
        .sw_rst_req (sw_rst_req),
        .rst_n_out  (rst_n_out),
        .seq_done   (seq_done),
        .lock_lost  (lock_lost),
        .state_out  (state_out)
`ifdef RESET_SEQ_RELOCK_CNT_EN
        ,
        .relock_cnt (relock_cnt)
`endif
    );

    always #5 clk_In = ~clk_In;

    always @(posedge clk_In) edge_no <= edge_no + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RST:   return 32'(rst_n_out);
            K_DONE:  return 32'(seq_done);
            K_LOST:  return 32'(lock_lost);
            K_STATE: return 32'(state_out);
`ifdef RESET_SEQ_RELOCK_CNT_EN
            K_RELOCK: return 32'(relock_cnt);
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Keep the queue ordered by edge so the monitor only looks at the head.
    task automatic expect_at(input string tag, input int e, input int kind, input logic [31:0] v);
        exp_t item;
        int   pos;
        item.edge_no = e;
        item.kind    = kind;
        item.val     = v;
        item.tag     = tag;
        pos = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].edge_no > e) begin
                pos = i;
                break;
            end
        end
        sb_q.insert(pos, item);
    endtask

    task automatic wait_until(input int e);
        while (edge_no < e) @(negedge clk_In);
    endtask

    always @(negedge clk_In) begin
        while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_no) begin
            exp_t item;
            item = sb_q.pop_front();
            check_eq(item.tag, observe(item.kind), item.val);
        end
    end

    initial begin
        int b;
        int budget;

        // Reset state
        repeat (3) @(negedge clk_In);
        check_eq("reset_rst", 32'(rst_n_out), 32'h0);
        check_eq("reset_done", 32'(seq_done), 32'h0);
        check_eq("reset_lost", 32'(lock_lost), 32'h0);
        check_eq("reset_state", 32'(state_out), 32'h0);
        rst_n_In = 1'b1;
        repeat (3) @(negedge clk_In);

        // Nominal release
        b = edge_no;
        clk_lock = 1'b1;
        expect_at("nom_wait_e2", b + 2, K_STATE, 0);
        expect_at("nom_filter_e3", b + 3, K_STATE, 1);
        expect_at("nom_filter_e102", b + 102, K_STATE, 1);
        expect_at("nom_release_e103", b + 103, K_STATE, 2);
        expect_at("nom_rst_e118", b + 118, K_RST, 4'b0000);
        expect_at("nom_rst_e119", b + 119, K_RST, 4'b0001);
        expect_at("nom_rst_e135", b + 135, K_RST, 4'b0011);
        expect_at("nom_rst_e151", b + 151, K_RST, 4'b0111);
        expect_at("nom_done_e166", b + 166, K_DONE, 0);
        expect_at("nom_rst_e167", b + 167, K_RST, 4'b1111);
        expect_at("nom_done_e167", b + 167, K_DONE, 1);
        expect_at("nom_run_e167", b + 167, K_STATE, 3);
        wait_until(b + 170);

        // Software reset from RUN
        b = edge_no;
        sw_rst_req = 1'b1;
        @(negedge clk_In);
        sw_rst_req = 1'b0;
        expect_at("sw_hold_state", b + 1, K_STATE, 4);
        expect_at("sw_hold_rst", b + 1, K_RST, 4'b0000);
        expect_at("sw_hold_done", b + 1, K_DONE, 0);
        expect_at("sw_hold_last", b + 32, K_STATE, 4);
        expect_at("sw_release", b + 33, K_STATE, 2);
        expect_at("sw_rst_pre", b + 48, K_RST, 4'b0000);
        expect_at("sw_rst_bit0", b + 49, K_RST, 4'b0001);
        expect_at("sw_rst_all", b + 97, K_RST, 4'b1111);
        expect_at("sw_run", b + 97, K_STATE, 3);
        expect_at("sw_lost", b + 97, K_LOST, 0);
        wait_until(b + 100);

        // Lock loss in RUN, then re-lock
        b = edge_no;
        clk_lock = 1'b0;
        expect_at("loss_run_e2", b + 2, K_STATE, 3);
        expect_at("loss_rst_e3", b + 3, K_RST, 4'b0000);
        expect_at("loss_done_e3", b + 3, K_DONE, 0);
        expect_at("loss_lost_e3", b + 3, K_LOST, 1);
        expect_at("loss_state_e3", b + 3, K_STATE, 0);
`ifdef RESET_SEQ_RELOCK_CNT_EN
        expect_at("loss_relock", b + 3, K_RELOCK, 1);
`endif
        wait_until(b + 10);
        b = edge_no;
        clk_lock = 1'b1;
        expect_at("relock_filter", b + 3, K_STATE, 1);
        expect_at("relock_release", b + 103, K_STATE, 2);
        expect_at("relock_rst", b + 167, K_RST, 4'b1111);
        expect_at("relock_done", b + 167, K_DONE, 1);
        expect_at("relock_lost", b + 167, K_LOST, 1);
        wait_until(b + 170);

        // Asynchronous reset between edges
        @(posedge clk_In);
        #2;
        rst_n_In = 1'b0;
        #1;
        check_eq("async_rst", 32'(rst_n_out), 32'h0);
        check_eq("async_done", 32'(seq_done), 32'h0);
        check_eq("async_lost", 32'(lock_lost), 32'h0);
        check_eq("async_state", 32'(state_out), 32'h0);
`ifdef RESET_SEQ_RELOCK_CNT_EN
        check_eq("async_relock", 32'(relock_cnt), 32'h0);
`endif
        clk_lock = 1'b0;
        #1;
        rst_n_In = 1'b1;
        @(negedge clk_In);
        wait_until(edge_no + 5);

        // Lock glitch during FILTER, then lock loss mid-RELEASE
        b = edge_no;
        clk_lock = 1'b1;
        expect_at("glitch_filter", b + 3, K_STATE, 1);
        expect_at("glitch_pre", b + 52, K_STATE, 1);
        expect_at("glitch_wait", b + 53, K_STATE, 0);
        expect_at("glitch_refilter", b + 56, K_STATE, 1);
        expect_at("glitch_no_early", b + 104, K_STATE, 1);
        expect_at("glitch_rst_e119", b + 119, K_RST, 4'b0000);
        expect_at("glitch_filter_end", b + 155, K_STATE, 1);
        expect_at("glitch_release", b + 156, K_STATE, 2);
        expect_at("glitch_rst_pre", b + 171, K_RST, 4'b0000);
        expect_at("glitch_rst_bit0", b + 172, K_RST, 4'b0001);
        expect_at("mid_rst_held", b + 190, K_RST, 4'b0011);
        expect_at("mid_state_held", b + 190, K_STATE, 2);
        expect_at("mid_rst_cleared", b + 191, K_RST, 4'b0000);
        expect_at("mid_done", b + 191, K_DONE, 0);
        expect_at("mid_lost", b + 191, K_LOST, 0);
        expect_at("mid_state", b + 191, K_STATE, 0);
        wait_until(b + 50);
        clk_lock = 1'b0;
        wait_until(b + 53);
        clk_lock = 1'b1;
        wait_until(b + 188);
        clk_lock = 1'b0;

        budget = 0;
        while (sb_q.size() > 0 && budget < 500) begin
            @(negedge clk_In);
            budget++;
        end
        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
